// File: rtl/fetch_unit_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Word-address width follows from the instruction width (32 -> 10).
  function automatic int unsigned addr_w_of(input int unsigned width);
    return width - 22;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic event_hit);
    return (event_hit && (value != '1)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: req/ack instruction-memory handshake between fetch and imem.
interface fetch_unit_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 10
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WIDTH-1:0]  imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_hold_buf.sv
// fetch_hold_buf: single-entry buffer parking a fetched word while IF/ID is stalled.
module fetch_hold_buf #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drop,
  input  logic [WIDTH-1:0]  load_instr,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              valid,
  output logic [WIDTH-1:0]  instr,
  output logic [ADDR_W-1:0] addr
);

  // Drop wins over load; payload only changes on load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= '0;
      addr  <= '0;
    end else if (drop) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      addr  <= load_addr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Optional FETCH_PERF_EN adds saturating perf_fetched/perf_stall/perf_killed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       ADDR_W   = addr_w_of(WIDTH),
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  fetch_unit_if.master      imem,
  output logic [WIDTH-1:0]  if_instr,
  output logic [ADDR_W-1:0] if_addr,
  output logic              if_en,
  output logic              if_flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_killed
`endif
);

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc;
  logic              kill, kill_n;
  logic              req_n;
  logic [ADDR_W-1:0] addr_n;
  logic              en_n, flush_n;
  logic [WIDTH-1:0]  instr_n;
  logic [ADDR_W-1:0] if_addr_n;
  logic              buf_load, buf_drop, buf_valid;
  logic [WIDTH-1:0]  buf_instr;
  logic [ADDR_W-1:0] buf_addr;

  assign pc_inc = pc + 1'b1;

  fetch_hold_buf #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .drop       (buf_drop),
    .load_instr (imem.imem_rdata),
    .load_addr  (pc_inc),
    .valid      (buf_valid),
    .instr      (buf_instr),
    .addr       (buf_addr)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next state, next PC and next registered outputs; redirect outranks ack and stall
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    kill_n    = kill;
    en_n      = 1'b0;
    flush_n   = 1'b0;
    instr_n   = if_instr;
    if_addr_n = if_addr;
    buf_load  = 1'b0;
    buf_drop  = 1'b0;
    addr_n    = imem.imem_addr;
    req_n     = 1'b0;

    case (state)
      ST_IDLE: begin
        state_n = ST_REQ;
        if (redirect) begin
          pc_n    = redirect_addr;
          flush_n = 1'b1;
        end
      end

      ST_REQ: begin
        if (imem.imem_ack) begin
          state_n = ST_GAP;
          kill_n  = 1'b0;
          if (redirect) begin
            pc_n    = redirect_addr;
            flush_n = 1'b1;
          end else if (kill) begin
            // stale word from before a redirect: discard
          end else if (stall) begin
            buf_load = 1'b1;
            state_n  = ST_HOLD;
          end else begin
            en_n      = 1'b1;
            instr_n   = imem.imem_rdata;
            if_addr_n = pc_inc;
            pc_n      = pc_inc;
          end
        end else if (redirect) begin
          // request must stay stable until acked, so mark it dead instead
          pc_n    = redirect_addr;
          flush_n = 1'b1;
          kill_n  = 1'b1;
        end
      end

      ST_GAP: begin
        state_n = ST_REQ;
        if (redirect) begin
          pc_n    = redirect_addr;
          flush_n = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_n     = redirect_addr;
          flush_n  = 1'b1;
          buf_drop = 1'b1;
          state_n  = ST_GAP;
        end else if (!stall && buf_valid) begin
          en_n      = 1'b1;
          instr_n   = buf_instr;
          if_addr_n = buf_addr;
          pc_n      = pc_inc;
          buf_drop  = 1'b1;
          state_n   = ST_REQ;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Address is captured only on entry to REQ and frozen while requesting
    req_n = (state_n == ST_REQ);
    if ((state_n == ST_REQ) && (state != ST_REQ)) addr_n = pc_n;
  end

  // PC, kill flag and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc             <= RESET_PC;
      kill           <= 1'b0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      if_en          <= 1'b0;
      if_flush       <= 1'b0;
      if_instr       <= WIDTH'(NOP_INSTR);
      if_addr        <= '0;
    end else begin
      pc             <= pc_n;
      kill           <= kill_n;
      imem.imem_req  <= req_n;
      imem.imem_addr <= addr_n;
      if_en          <= en_n;
      if_flush       <= flush_n;
      if_instr       <= instr_n;
      if_addr        <= if_addr_n;
    end
  end

`ifdef FETCH_PERF_EN
  logic killed_ack;
  assign killed_ack = (state == ST_REQ) && imem.imem_ack && (redirect || kill);

  // Saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_killed  <= '0;
    end else begin
      perf_fetched <= sat_inc(perf_fetched, if_en);
      perf_stall   <= sat_inc(perf_stall, state == ST_HOLD);
      perf_killed  <= sat_inc(perf_killed, killed_ack);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
module tb_fetch_unit;

  localparam int unsigned       WIDTH    = 32;
  localparam int unsigned       ADDR_W   = 10;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic [WIDTH-1:0]  if_instr;
  logic [ADDR_W-1:0] if_addr;
  logic              if_en;
  logic              if_flush;

  fetch_unit_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) imem_bus ();

  fetch_unit #(
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem          (imem_bus),
    .if_instr      (if_instr),
    .if_addr       (if_addr),
    .if_en         (if_en),
    .if_flush      (if_flush)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] target;
    int                due;
  } redir_t;

  redir_t redir_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int delivered = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Program memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    if (a == '0) return 32'h2008_0005;
    x = {22'h0, a};
    return (x * 32'h9E37_79B1) ^ {a, 22'h15A5A5};
  endfunction

  // Memory responder: random 0..3 cycle ack latency, occasional stray acks while idle
  initial begin
    int   lat;
    logic waiting;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
    waiting = 1'b0;
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_bus.imem_ack = 1'b0;
      if (!reset) begin
        waiting = 1'b0;
      end else if (imem_bus.imem_req) begin
        if (!waiting) begin
          waiting = 1'b1;
          lat = $urandom_range(0, 3);
        end
        if (lat == 0) begin
          imem_bus.imem_ack   = 1'b1;
          imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
          waiting = 1'b0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = $urandom;
      end
    end
  end

  // Monitor: reference model is "sequential program from pc, restarting at each redirect target"
  initial begin
    logic [ADDR_W-1:0] exp_pc, nxt, held_addr;
    logic              prev_req, prev_stall, exp_flush;
    int                idle_cnt;
    exp_pc = RESET_PC;
    held_addr = '0;
    prev_req = 1'b0;
    prev_stall = 1'b0;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_pc = RESET_PC;
        redir_q.delete();
        prev_req = 1'b0;
        prev_stall = 1'b0;
        idle_cnt = 0;
      end else begin
        exp_flush = (redir_q.size() > 0) && (redir_q[0].due == cyc);
        check("if_flush", if_flush, exp_flush);
        if (exp_flush) begin
          exp_pc = redir_q[0].target;
          redir_q.pop_front();
          check("if_en_on_flush", if_en, 1'b0);
        end else if (if_en) begin
          nxt = exp_pc + 1'b1;
          check("if_addr", if_addr, nxt);
          check("if_instr", if_instr, mem_word(exp_pc));
          check("if_en_while_stalled", prev_stall, 1'b0);
          exp_pc = nxt;
          delivered++;
        end
        if (if_en) idle_cnt = 0;
        else       idle_cnt++;
        if (idle_cnt > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL progress: no if_en for %0d cycles, expected at most 200", idle_cnt);
          idle_cnt = 0;
        end
        if (imem_bus.imem_req && !prev_req) check("req_addr", imem_bus.imem_addr, exp_pc);
        if (imem_bus.imem_req && prev_req)  check("req_addr_stable", imem_bus.imem_addr, held_addr);
        held_addr = imem_bus.imem_addr;
        prev_req = imem_bus.imem_req;
        prev_stall = stall;
      end
    end
  end

  task automatic run_cycles(input int n);
    int     stall_left;
    redir_t r;
    stall_left = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      redirect = ($urandom_range(0, 11) == 0);
      if (redirect) begin
        case ($urandom_range(0, 3))
          0:       redirect_addr = 10'h3FE;
          1:       redirect_addr = 10'h3FF;
          default: redirect_addr = 10'($urandom);
        endcase
        r.target = redirect_addr;
        r.due    = cyc + 1;
        redir_q.push_back(r);
      end
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else if ($urandom_range(0, 5) == 0) begin
        stall = 1'b1;
        stall_left = $urandom_range(0, 4);
      end else begin
        stall = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    stall = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_imem_req"},  imem_bus.imem_req, 1'b0);
    check({tag, "_imem_addr"}, imem_bus.imem_addr, '0);
    check({tag, "_if_en"},     if_en, 1'b0);
    check({tag, "_if_flush"},  if_flush, 1'b0);
    check({tag, "_if_instr"},  if_instr, '0);
    check({tag, "_if_addr"},   if_addr, '0);
  endtask

  initial begin
    bit seen_req;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    #1 reset = 1'b0;
    #1 check_outputs_zero("reset");
    #20 reset = 1'b1;

    run_cycles(1500);

    // Asynchronous reset while a request is outstanding
    seen_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (imem_bus.imem_req) begin
        seen_req = 1'b1;
        break;
      end
    end
    if (!seen_req) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_req: imem_req stayed 0 for 50 cycles, expected 1");
    end
    #1 reset = 1'b0;
    #1 check_outputs_zero("async_reset");
    repeat (3) begin
      @(negedge clk);
      check("req_in_reset", imem_bus.imem_req, 1'b0);
    end
    #2 reset = 1'b1;

    run_cycles(1500);

    repeat (30) @(posedge clk);
    check("redirects_unflushed", redir_q.size(), 0);
    n_cmp++;
    if (delivered < 100) begin
      n_bad++;
      $display("FAIL throughput: delivered %0d instructions, expected at least 100", delivered);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage; the producer feeding the IF/ID pipeline register.
- Holds the PC and fetches words over a req/ack instruction-memory handshake.
- Drives instruction, next-PC word address, write-enable and flush into the IF/ID register.
- Honours hazard stalls and branch/jump redirects, and never loses or duplicates an instruction.

Parameters:
WIDTH, 32, instruction width in bits
ADDR_W, WIDTH-22 (10), PC / word-address width
RESET_PC, 0, PC value loaded at reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
stall  in  1  hazard unit: IF/ID must hold, no new write
redirect  in  1  branch/jump taken this cycle
redirect_addr  in  ADDR_W  target word address
imem_req  out  1  fetch request, held until ack
imem_addr  out  ADDR_W  fetch word address, stable while imem_req=1
imem_ack  in  1  one-cycle pulse: imem_rdata valid
imem_rdata  in  WIDTH  fetched instruction
if_instr  out  WIDTH  instruction to IF/ID register
if_addr  out  ADDR_W  PC+1 word address to IF/ID register
if_en  out  1  one-cycle IF/ID write enable
if_flush  out  1  one-cycle IF/ID flush

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=IDLE, kill=0, all outputs 0. No request is issued while reset is low.
- All outputs are registered.
- States:
  - IDLE: one cycle after reset release; goes to REQ.
  - REQ: imem_req=1, imem_addr=pc, both held until imem_ack.
  - GAP: one cycle with imem_req=0 after every ack.
  - HOLD: fetched word buffered while stall=1; imem_req=0.
- Ack in REQ, kill=0, stall=0:
  - Next cycle: if_instr=imem_rdata, if_addr=pc+1, if_en=1 for one cycle.
  - pc<=pc+1; state goes to GAP, then REQ.
- Ack in REQ, kill=0, stall=1: word goes into the hold buffer; state goes to HOLD.
- HOLD, first cycle with stall=0: present the buffer with if_en=1 next cycle, pc<=pc+1, then REQ.
- Redirect (priority over stall and ack; below reset):
  - pc<=redirect_addr; if_flush=1 next cycle for one cycle; if_en is 0 that cycle.
  - REQ without ack same cycle: set kill=1 and keep req/addr stable (protocol rule). The returned word is discarded, kill clears, then GAP, then REQ at the new pc.
  - Ack in the same cycle as redirect: data discarded.
  - In HOLD: buffer dropped; state goes to GAP.
  - A second redirect while kill=1: pc updated; kill stays set.
- imem_ack while imem_req=0: ignored.
- pc and if_addr wrap modulo 2^ADDR_W (0x3FF+1 = 0x000).
- Stall with nothing pending (REQ/GAP): the fetch proceeds; the result parks in HOLD when it returns.
- Latency: minimum 3 cycles per instruction (req, ack, gap); if_en follows ack by 1 cycle.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds 32-bit saturating counters perf_fetched (if_en pulses), perf_stall (cycles in HOLD) and perf_killed (discarded acks), exposed as output ports. Counters are cleared by reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg: state encoding (IDLE, REQ, GAP, HOLD), NOP_INSTR=32'h0, ADDR_W derivation.
- One sub-module, fetch_hold_buf: single-entry WIDTH+ADDR_W holding register with load/drop/valid. The FSM and PC stay in fetch_unit.

Test Plan:
1. Release reset, ack 1 cycle after req at addr 0 with 0x20080005 -> if_instr=0x20080005, if_addr=1, if_en 1-cycle pulse; next imem_addr=1 after one gap cycle.
2. Ack latency 3 cycles at pc=2 -> imem_req and imem_addr=2 stable all 3 cycles; exactly one if_en.
3. stall=1 when ack brings 0xAC290000, stall held 4 cycles -> if_en=0, imem_req=0 during HOLD; when stall drops, if_en=1 with 0xAC290000, if_addr=pc+1.
4. redirect to 0x100 while req at pc=5 outstanding, ack 2 cycles later -> if_flush 1-cycle pulse; word discarded with no if_en; next imem_addr=0x100.
5. pc=0x3FF fetched -> if_addr=0x000; next imem_addr=0x000.
6. Drive reset=0 mid-request -> all outputs 0 immediately (async); after release, first req at RESET_PC.
